// File: rtl/p405s_dtlb_shadow_array.sv
// Data-side shadow TLB: ENTRIES fully associative translations, round-robin refill from the UTLB.
// Optional P405S_DSHADOW_MULTIHIT_EN adds a multiHit output and flushes the array on multi-match.
module p405s_dtlb_shadow_array #(
  parameter int ENTRIES = 4,
  parameter int EA_W    = 22,
  parameter int SIZE_W  = 7,
  parameter int IDX_W   = 2
) (
  input  logic              CB,
  input  logic              resetCore_NEG,
  input  logic              lookupValid,
  input  logic [EA_W-1:0]   lookupEa,
  input  logic              lookupState,
  input  logic              msrDR_NEG,
  output logic              Hit,
  output logic              Miss,
  output logic [IDX_W-1:0]  hitIdx,
  output logic              missReq,
  output logic [EA_W-1:0]   missEa,
  input  logic              fillValid,
  input  logic [EA_W-1:0]   fillEpn,
  input  logic [SIZE_W-1:0] fillSize,
  input  logic              fillState,
  input  logic              invalidateAll,
  output logic              busy
`ifdef P405S_DSHADOW_MULTIHIT_EN
  ,
  output logic              multiHit
`endif
);

  typedef enum logic [1:0] {IDLE, MISS_WAIT, FILL} state_t;

  localparam logic [ENTRIES-1:0] ONE_ENTRY = 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(ENTRIES - 1);

  state_t             state_reg, state_next;
  logic [EA_W-1:0]    epn_mem  [ENTRIES];
  logic [SIZE_W-1:0]  size_mem [ENTRIES];
  logic               tag_mem  [ENTRIES];
  logic [ENTRIES-1:0] valid_reg;
  logic [IDX_W-1:0]   victim_reg;
  logic [EA_W-1:0]    fill_epn_reg;
  logic [SIZE_W-1:0]  fill_size_reg;
  logic               fill_state_reg;

  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0]   hit_idx_next;
  logic               any_match;
  logic               lookup_go;
  logic               hit_next, miss_next;
  logic               capture_miss, capture_fill, write_fill, clear_all;
`ifdef P405S_DSHADOW_MULTIHIT_EN
  logic               multi_match;
  logic               multi_next;
`endif

  // Vectors are little-endian here: size bit j masks EPN bits 2j+1:2j (the page-offset end).
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [EA_W-1:0] ign_mask;
      for (genvar gb = 0; gb < SIZE_W; gb++) begin : g_mask
        assign ign_mask[2*gb+1:2*gb] = {2{size_mem[gi][gb]}};
      end
      if (EA_W > 2*SIZE_W) begin : g_pad
        assign ign_mask[EA_W-1:2*SIZE_W] = '0;
      end
      assign match[gi] = valid_reg[gi] & (tag_mem[gi] == lookupState) &
                         (((epn_mem[gi] ^ lookupEa) & ~ign_mask) == '0);
    end
  endgenerate

  always_comb begin
    hit_idx_next = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx_next = IDX_W'(i);
    end
  end

  assign any_match = |match;
  assign lookup_go = lookupValid & ~msrDR_NEG & ~invalidateAll;
`ifdef P405S_DSHADOW_MULTIHIT_EN
  assign multi_match = |(match & (match - ONE_ENTRY));
`endif

  always_comb begin
    state_next   = state_reg;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    capture_miss = 1'b0;
    capture_fill = 1'b0;
    write_fill   = 1'b0;
    clear_all    = invalidateAll;
`ifdef P405S_DSHADOW_MULTIHIT_EN
    multi_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (lookup_go) begin
`ifdef P405S_DSHADOW_MULTIHIT_EN
          if (multi_match) begin
            miss_next  = 1'b1;
            multi_next = 1'b1;
            clear_all  = 1'b1;
          end else
`endif
          if (any_match) begin
            hit_next = 1'b1;
          end else begin
            miss_next    = 1'b1;
            capture_miss = 1'b1;
            state_next   = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        if (invalidateAll) begin
          state_next = IDLE;
        end else if (fillValid) begin
          capture_fill = 1'b1;
          state_next   = FILL;
        end
      end
      FILL: begin
        state_next = IDLE;
        write_fill = ~invalidateAll;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CB or negedge resetCore_NEG) begin
    if (!resetCore_NEG) begin
      state_reg  <= IDLE;
      valid_reg  <= '0;
      victim_reg <= '0;
      Hit        <= 1'b0;
      Miss       <= 1'b0;
      hitIdx     <= '0;
      missEa     <= '0;
`ifdef P405S_DSHADOW_MULTIHIT_EN
      multiHit   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      Hit       <= hit_next;
      Miss      <= miss_next;
      hitIdx    <= hit_next ? hit_idx_next : '0;
`ifdef P405S_DSHADOW_MULTIHIT_EN
      multiHit  <= multi_next;
`endif
      if (capture_miss) missEa <= lookupEa;
      if (clear_all) valid_reg <= '0;
      else if (write_fill) valid_reg[victim_reg] <= 1'b1;
      if (write_fill) victim_reg <= (victim_reg == LAST_IDX) ? '0 : victim_reg + IDX_W'(1);
    end
  end

  // Entry payload needs no reset: an entry is only observable through its valid bit.
  always_ff @(posedge CB) begin
    if (capture_fill) begin
      fill_epn_reg   <= fillEpn;
      fill_size_reg  <= fillSize;
      fill_state_reg <= fillState;
    end
    if (write_fill) begin
      epn_mem[victim_reg]  <= fill_epn_reg;
      size_mem[victim_reg] <= fill_size_reg;
      tag_mem[victim_reg]  <= fill_state_reg;
    end
  end

  assign missReq = (state_reg == MISS_WAIT);
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_p405s_dtlb_shadow_array.sv
// Directed bench for p405s_dtlb_shadow_array: table of lookups plus hand-written fill/flush sequences.
module tb_p405s_dtlb_shadow_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [21:0] lookup_ea = '0;
  logic        lookup_state = 1'b0;
  logic        dr_off = 1'b0;
  logic        hit, miss;
  logic [1:0]  hit_idx;
  logic        miss_req;
  logic [21:0] miss_ea;
  logic        fill_valid = 1'b0;
  logic [21:0] fill_epn = '0;
  logic [6:0]  fill_size = '0;
  logic        fill_state = 1'b0;
  logic        inv_all = 1'b0;
  logic        busy;
`ifdef P405S_DSHADOW_MULTIHIT_EN
  logic        multi_hit;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  p405s_dtlb_shadow_array dut (
    .CB(clk), .resetCore_NEG(rst_n),
    .lookupValid(lookup_valid), .lookupEa(lookup_ea), .lookupState(lookup_state),
    .msrDR_NEG(dr_off), .Hit(hit), .Miss(miss), .hitIdx(hit_idx),
    .missReq(miss_req), .missEa(miss_ea), .fillValid(fill_valid),
    .fillEpn(fill_epn), .fillSize(fill_size), .fillState(fill_state),
    .invalidateAll(inv_all), .busy(busy)
`ifdef P405S_DSHADOW_MULTIHIT_EN
    , .multiHit(multi_hit)
`endif
  );

  typedef struct {
    logic        v;
    logic [21:0] ea;
    logic        st;
    logic        dr;
    logic        eh;
    logic        em;
    logic [1:0]  eidx;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [21:0] ea, input logic st, input logic dr);
    lookup_valid = 1'b1;
    lookup_ea    = ea;
    lookup_state = st;
    dr_off       = dr;
    tick();
    lookup_valid = 1'b0;
    dr_off       = 1'b0;
    $display("lookup ea=%h st=%0d dr_off=%0d -> hit=%0d miss=%0d idx=%0d", ea, st, dr, hit, miss, hit_idx);
  endtask

  task automatic fill(input logic [21:0] epn, input logic [6:0] sz, input logic st);
    fill_valid = 1'b1;
    fill_epn   = epn;
    fill_size  = sz;
    fill_state = st;
    tick();
    fill_valid = 1'b0;
    tick();
    $display("fill epn=%h size=%h st=%0d", epn, sz, st);
  endtask

  initial begin
    // Entries at table time: 0:0ABCD/00, 1:0AB00/03, 2:0AB10/00, all state 0
    tbl[0] = '{1'b1, 22'h0ABCD, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{1'b1, 22'h0AB00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[2] = '{1'b1, 22'h0AB03, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[3] = '{1'b1, 22'h0AB0F, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[4] = '{1'b1, 22'h0AB10, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[5] = '{1'b1, 22'h0ABCD, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[6] = '{1'b1, 22'h0AB10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[7] = '{1'b0, 22'h0ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[8] = '{1'b1, 22'h2AB03, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};

    repeat (3) tick();
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_idx", 32'(hit_idx), 32'd0);
    chk("rst_missreq", 32'(miss_req), 32'd0);
    chk("rst_missea", 32'(miss_ea), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // First miss and its fill
    lookup(22'h0ABCD, 1'b0, 1'b0);
    chk("m1_miss", 32'(miss), 32'd1);
    chk("m1_hit", 32'(hit), 32'd0);
    chk("m1_req", 32'(miss_req), 32'd1);
    chk("m1_ea", 32'(miss_ea), 32'h0ABCD);
    chk("m1_busy", 32'(busy), 32'd1);
    tick();
    chk("m1_pulse", 32'(miss), 32'd0);
    chk("m1_req_held", 32'(miss_req), 32'd1);
    fill(22'h0ABCD, 7'h00, 1'b0);
    chk("f1_busy", 32'(busy), 32'd0);
    chk("f1_req", 32'(miss_req), 32'd0);
    lookup(22'h0ABCD, 1'b0, 1'b0);
    chk("r1_hit", 32'(hit), 32'd1);
    chk("r1_idx", 32'(hit_idx), 32'd0);

    // Size mask 03 covers the low 4 EPN bits
    lookup(22'h0AB0F, 1'b0, 1'b0);
    chk("sz_pre_miss", 32'(miss), 32'd1);
    fill(22'h0AB00, 7'h03, 1'b0);
    lookup(22'h0AB0F, 1'b0, 1'b0);
    chk("sz_hit", 32'(hit), 32'd1);
    chk("sz_idx", 32'(hit_idx), 32'd1);
    lookup(22'h0AB10, 1'b0, 1'b0);
    chk("sz_out_miss", 32'(miss), 32'd1);
    chk("sz_out_hit", 32'(hit), 32'd0);
    fill(22'h0AB10, 7'h00, 1'b0);

    for (int i = 0; i < 9; i++) begin
      lookup_valid = tbl[i].v;
      lookup_ea    = tbl[i].ea;
      lookup_state = tbl[i].st;
      dr_off       = tbl[i].dr;
      tick();
      lookup_valid = 1'b0;
      dr_off       = 1'b0;
      $display("vec %0d ea=%h v=%0d dr_off=%0d -> hit=%0d miss=%0d idx=%0d", i, tbl[i].ea, tbl[i].v, tbl[i].dr, hit, miss, hit_idx);
      chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].eh));
      chk($sformatf("vec%0d_miss", i), 32'(miss), 32'(tbl[i].em));
      if (tbl[i].eh) chk($sformatf("vec%0d_idx", i), 32'(hit_idx), 32'(tbl[i].eidx));
      chk($sformatf("vec%0d_req", i), 32'(miss_req), 32'd0);
    end

    // State tag mismatch misses; non-thermometer mask 02 ignores EPN bits 3:2 only
    lookup(22'h0ABCD, 1'b1, 1'b0);
    chk("tag_miss", 32'(miss), 32'd1);
    fill(22'h0C000, 7'h02, 1'b0);
    lookup(22'h0C00C, 1'b0, 1'b0);
    chk("nt_hit", 32'(hit), 32'd1);
    chk("nt_idx", 32'(hit_idx), 32'd3);
    lookup(22'h0C001, 1'b0, 1'b0);
    chk("nt_miss", 32'(miss), 32'd1);
    fill(22'h0C001, 7'h00, 1'b0);
    lookup(22'h0C001, 1'b0, 1'b0);
    chk("wrap_hit", 32'(hit), 32'd1);
    chk("wrap_idx", 32'(hit_idx), 32'd0);
    lookup(22'h0ABCD, 1'b0, 1'b0);
    chk("evict_miss", 32'(miss), 32'd1);

    // Flush aborts the wait, beating a same-cycle fill
    inv_all    = 1'b1;
    fill_valid = 1'b1;
    fill_epn   = 22'h0ABCD;
    fill_size  = 7'h00;
    fill_state = 1'b0;
    tick();
    inv_all    = 1'b0;
    fill_valid = 1'b0;
    chk("abort_req", 32'(miss_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    chk("abort_nofill", 32'(busy), 32'd0);
    lookup(22'h0C001, 1'b0, 1'b0);
    chk("flushed_miss", 32'(miss), 32'd1);
    fill(22'h0E000, 7'h00, 1'b0);
    lookup(22'h0E000, 1'b0, 1'b0);
    chk("victim_kept_hit", 32'(hit), 32'd1);
    chk("victim_kept_idx", 32'(hit_idx), 32'd1);

    // fillValid in IDLE is ignored
    fill_valid = 1'b1;
    fill_epn   = 22'h0D000;
    tick();
    fill_valid = 1'b0;
    chk("idle_fill_busy", 32'(busy), 32'd0);
    lookup(22'h0D000, 1'b0, 1'b0);
    chk("idle_fill_miss", 32'(miss), 32'd1);
    fill(22'h0D000, 7'h00, 1'b0);
    lookup(22'h0D000, 1'b0, 1'b0);
    chk("d_hit", 32'(hit), 32'd1);
    chk("d_idx", 32'(hit_idx), 32'd2);

    // Flush wins over a same-cycle lookup
    inv_all = 1'b1;
    lookup(22'h0D000, 1'b0, 1'b0);
    inv_all = 1'b0;
    chk("invlk_hit", 32'(hit), 32'd0);
    chk("invlk_miss", 32'(miss), 32'd0);
    chk("invlk_busy", 32'(busy), 32'd0);
    lookup(22'h0D000, 1'b0, 1'b0);
    chk("invlk_after_miss", 32'(miss), 32'd1);

    // Two entries (3 and 0) holding 00010
    fill(22'h00010, 7'h00, 1'b0);
    lookup(22'h00020, 1'b0, 1'b0);
    chk("dup_pre_miss", 32'(miss), 32'd1);
    fill(22'h00010, 7'h00, 1'b0);
    lookup(22'h00010, 1'b0, 1'b0);
`ifdef P405S_DSHADOW_MULTIHIT_EN
    chk("mh_flag", 32'(multi_hit), 32'd1);
    chk("mh_miss", 32'(miss), 32'd1);
    chk("mh_hit", 32'(hit), 32'd0);
    chk("mh_noreq", 32'(miss_req), 32'd0);
    lookup(22'h00010, 1'b0, 1'b0);
    chk("mh_cleared_miss", 32'(miss), 32'd1);
    chk("mh_flag_pulse", 32'(multi_hit), 32'd0);
`else
    chk("dup_hit", 32'(hit), 32'd1);
    chk("dup_idx_lowest", 32'(hit_idx), 32'd0);
    lookup(22'h0FFFF, 1'b0, 1'b0);
    chk("last_miss", 32'(miss), 32'd1);
`endif

    // Asynchronous reset in the middle of a miss
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req", 32'(miss_req), 32'd0);
    chk("arst_miss", 32'(miss), 32'd0);
    chk("arst_missea", 32'(miss_ea), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    lookup(22'h00010, 1'b0, 1'b0);
    chk("post_rst_miss", 32'(miss), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
